// File: rtl/alu_sub_div_seq.sv
// Iterative restoring divider: one WIDTH+1-bit trial subtraction per clock,
// start/busy/done handshake, sign fixup and special cases in a final cycle.
//
// state   | meaning
// S_IDLE  | waiting for start; results and flags held
// S_ITER  | producing one quotient bit per cycle, MSB first
// S_FIXUP | apply signs or special-case results, pulse done
module alu_sub_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIXUP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dzo_q, dzo_d;
    logic             ovo_q, ovo_d;
    logic             done_q, done_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             is_dz, is_ovf;
    logic [WIDTH:0]   shifted, diff;
    logic             borrow;

    assign dvd_neg = signed_op & dividend[WIDTH-1];
    assign dvs_neg = signed_op & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;
    assign is_dz   = (divisor == '0);
    assign is_ovf  = signed_op & (dividend == MIN_VAL) & (divisor == '1);

    // Partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
    assign shifted = {rem_q, num_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, den_q};
    assign borrow  = diff[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dzo_d   = dzo_q;
        ovo_d   = ovo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = dvd_mag;
                    den_d   = dvs_mag;
                    dvd_d   = dividend;
                    qneg_d  = dvd_neg ^ dvs_neg;
                    rneg_d  = dvd_neg;
                    dz_d    = is_dz;
                    ovf_d   = is_ovf;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = (is_dz || is_ovf) ? S_FIXUP : S_ITER;
                end
            end
            S_ITER: begin
                rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                num_d = {num_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dz_q) begin
                    quo_d = '1;
                    rmd_d = dvd_q;
                    dzo_d = 1'b1;
                    ovo_d = 1'b0;
                end else if (ovf_q) begin
                    quo_d = dvd_q;
                    rmd_d = '0;
                    dzo_d = 1'b0;
                    ovo_d = 1'b1;
                end else begin
                    quo_d = qneg_q ? -num_q : num_q;
                    rmd_d = rneg_q ? -rem_q : rem_q;
                    dzo_d = 1'b0;
                    ovo_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dzo_q   <= 1'b0;
            ovo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dzo_q   <= dzo_d;
            ovo_q   <= ovo_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dzo_q;
    assign overflow    = ovo_q;

endmodule
